// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR scheduler slice.
package lfsr_pkg;
  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 4'b1000;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  // Index width for n requesters, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lfsr_sched_if.sv
// Requester-side bus of the LFSR scheduler: requests in, grant/completion out.
interface lfsr_sched_if
  import lfsr_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 4
);
  localparam int IDX_W = idx_w(NREQ);

  logic [NREQ-1:0]        req;
  logic [LFSR_W*NREQ-1:0] seed;
  logic [CNT_W*NREQ-1:0]  nshift;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic                   done;
  logic [IDX_W-1:0]       done_id;
  logic [LFSR_W-1:0]      result;
  logic                   err_zero_seed;

  modport master (
    output req, seed, nshift,
    input  gnt, busy, done, done_id, result, err_zero_seed
  );

  modport slave (
    input  req, seed, nshift,
    output gnt, busy, done, done_id, result, err_zero_seed
  );
endinterface

// File: rtl/lfsr_sched_rr_arb.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_arb
  import lfsr_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_j;
  logic             w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Wrap ptr+k back into 0..NREQ-1 without a modulo operator.
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NREQ))
        w_sum = w_sum - (IDX_W+1)'(NREQ);
      w_j = w_sum[IDX_W-1:0];
      if (!w_found && i_req[w_j]) begin
        w_found  = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx    = w_j;
      end
    end
    o_vld = w_found;
  end
endmodule

// File: rtl/lfsr_sched.sv
// Arbitrates requesters onto one shared 4-bit shift register: load seed,
// shift N times, return the register value with a completion pulse.
module lfsr_sched
  import lfsr_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  lfsr_sched_if.slave       bus,
  output logic              sr_load,
  output logic [LFSR_W-1:0] sr_d,
  output logic              sr_shift_en,
  input  logic [LFSR_W-1:0] sr_q
);
  localparam int IDX_W = idx_w(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  state_t            r_state, w_nxt;
  logic [IDX_W-1:0]  r_ptr, r_id, r_done_id;
  logic [LFSR_W-1:0] r_seed, r_result;
  logic [CNT_W-1:0]  r_cnt;

  logic [NREQ-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]  w_arb_idx;
  logic              w_arb_vld;
  logic              w_take;
  logic [LFSR_W-1:0] w_seed_sel;
  logic [CNT_W-1:0]  w_cnt_sel;

  rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_vld (w_arb_vld)
  );

  // Grant is combinational from req, so suppress it while rst is held.
  assign w_take     = (r_state == IDLE) && w_arb_vld && !rst;
  assign w_seed_sel = bus.seed[w_arb_idx*LFSR_W +: LFSR_W];
  assign w_cnt_sel  = bus.nshift[w_arb_idx*CNT_W +: CNT_W];

  always_comb begin
    w_nxt             = r_state;
    bus.gnt           = '0;
    bus.err_zero_seed = 1'b0;
    bus.busy          = (r_state != IDLE);
    bus.done          = 1'b0;
    sr_load           = 1'b0;
    sr_d              = '0;
    sr_shift_en       = 1'b0;
    case (r_state)
      IDLE: if (w_take) begin
        bus.gnt           = w_arb_gnt;
        bus.err_zero_seed = (w_seed_sel == '0);
        w_nxt             = LOAD;
      end
      LOAD: begin
        sr_load = 1'b1;
        sr_d    = r_seed;
        w_nxt   = (r_cnt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        sr_shift_en = 1'b1;
        if (r_cnt == CNT_W'(1)) w_nxt = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        w_nxt    = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Show the job's index during the done pulse, then the held copy.
  assign bus.done_id = (r_state == DONE) ? r_id : r_done_id;
  assign bus.result  = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_done_id <= '0;
      r_seed    <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        IDLE: if (w_take) begin
          r_seed <= (w_seed_sel == '0) ? ZERO_SEED_SUB : w_seed_sel;
          r_cnt  <= w_cnt_sel;
          r_id   <= w_arb_idx;
          r_ptr  <= (w_arb_idx == LAST_IDX) ? '0 : w_arb_idx + 1'b1;
        end
        SHIFT: r_cnt <= r_cnt - 1'b1;
        DONE: begin
          r_result  <= sr_q;
          r_done_id <= r_id;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_sched.sv
// Directed bench for lfsr_sched with a behavioural shift register beside it.
module tb_lfsr_sched;
  logic       clk;
  logic       rst;
  logic       sr_load, sr_shift_en;
  logic [3:0] sr_d, sr_q;
  int         n_assert = 0;
  int         n_fail   = 0;

  lfsr_sched_if #(.NREQ(2), .CNT_W(4)) bus ();

  lfsr_sched #(.NREQ(2), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sr_load     (sr_load),
    .sr_d        (sr_d),
    .sr_shift_en (sr_shift_en),
    .sr_q        (sr_q)
  );

  // The shared shift register as it sits at the parent level.
  always_ff @(posedge clk) begin
    if (rst)              sr_q <= 4'h0;
    else if (sr_load)     sr_q <= sr_d;
    else if (sr_shift_en) sr_q <= {sr_q[0] ^ sr_q[1], sr_q[3:1]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"},     8'(bus.gnt),           8'h0);
    chk({tag, ".busy"},    8'(bus.busy),          8'h0);
    chk({tag, ".done"},    8'(bus.done),          8'h0);
    chk({tag, ".done_id"}, 8'(bus.done_id),       8'h0);
    chk({tag, ".result"},  8'(bus.result),        8'h0);
    chk({tag, ".err"},     8'(bus.err_zero_seed), 8'h0);
    chk({tag, ".load"},    8'(sr_load),           8'h0);
    chk({tag, ".d"},       8'(sr_d),              8'h0);
    chk({tag, ".shift"},   8'(sr_shift_en),       8'h0);
  endtask

  initial begin
    logic [1:0] eg;
    rst = 1'b1;
    bus.req = 2'b11;
    bus.seed = 8'h68;
    bus.nshift = 8'h23;

    // Reset with all requests high
    tick(); #1; chk_zero("rst0");
    tick(); #1; chk_zero("rst1");

    // Single job: req0, seed 1000, nshift 3
    tick(); rst = 1'b0; #1;
    chk("rel.gnt", 8'(bus.gnt), 8'h1);
    chk("rel.err", 8'(bus.err_zero_seed), 8'h0);
    tick(); bus.req = 2'b00; #1;
    chk("s1.load", 8'(sr_load), 8'h1);
    chk("s1.d", 8'(sr_d), 8'h8);
    chk("s1.busy", 8'(bus.busy), 8'h1);
    chk("s1.shift0", 8'(sr_shift_en), 8'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("s1.shift", 8'(sr_shift_en), 8'h1);
      chk("s1.noload", 8'(sr_load), 8'h0);
      if (i == 0) chk("s1.q_seed", 8'(sr_q), 8'h8);
    end
    tick(); #1;
    chk("s1.done", 8'(bus.done), 8'h1);
    chk("s1.done_id", 8'(bus.done_id), 8'h0);
    chk("s1.shift_off", 8'(sr_shift_en), 8'h0);
    chk("s1.q", 8'(sr_q), 8'h9);
    tick(); #1;
    chk("s1.result", 8'(bus.result), 8'h9);
    chk("s1.done_lo", 8'(bus.done), 8'h0);
    chk("s1.idle", 8'(bus.busy), 8'h0);

    // Zero seed: req0, seed 0000, nshift 5
    tick(); bus.req = 2'b01; bus.seed = 8'h60; bus.nshift = 8'h25; #1;
    chk("zs.gnt", 8'(bus.gnt), 8'h1);
    chk("zs.err", 8'(bus.err_zero_seed), 8'h1);
    tick(); bus.req = 2'b00; #1;
    chk("zs.err_lo", 8'(bus.err_zero_seed), 8'h0);
    chk("zs.load", 8'(sr_load), 8'h1);
    chk("zs.d", 8'(sr_d), 8'h8);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("zs.shift", 8'(sr_shift_en), 8'h1);
    end
    tick(); #1;
    chk("zs.done", 8'(bus.done), 8'h1);
    chk("zs.done_id", 8'(bus.done_id), 8'h0);
    tick(); #1;
    chk("zs.result", 8'(bus.result), 8'h6);

    // Zero count: req1 only, seed 0101, nshift 0
    tick(); bus.req = 2'b10; bus.seed = 8'h58; bus.nshift = 8'h03; #1;
    chk("zc.gnt", 8'(bus.gnt), 8'h2);
    tick(); bus.req = 2'b00; #1;
    chk("zc.load", 8'(sr_load), 8'h1);
    chk("zc.d", 8'(sr_d), 8'h5);
    tick(); #1;
    chk("zc.done", 8'(bus.done), 8'h1);
    chk("zc.done_id", 8'(bus.done_id), 8'h1);
    chk("zc.noshift", 8'(sr_shift_en), 8'h0);
    tick(); #1;
    chk("zc.result", 8'(bus.result), 8'h5);
    chk("zc.id_held", 8'(bus.done_id), 8'h1);
    chk("zc.idle", 8'(bus.busy), 8'h0);

    // Fairness: both held, nshift 1; seed0 0011 -> 0001, seed1 0110 -> 1011
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 0) begin
        bus.req = 2'b11; bus.seed = 8'h63; bus.nshift = 8'h11;
      end
      #1;
      eg = (k % 4 != 0) ? 2'b00 : (((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
      chk("fair.gnt", 8'(bus.gnt), 8'(eg));
      if (k % 4 == 3) chk("fair.done_id", 8'(bus.done_id), 8'(((k / 4) % 2)));
      if (k % 4 == 0 && k > 0)
        chk("fair.result", 8'(bus.result), (((k / 4) % 2) == 1) ? 8'h1 : 8'hB);
    end

    // Reset during the second SHIFT cycle of an nshift-5 job
    tick(); bus.req = 2'b01; bus.seed = 8'h68; bus.nshift = 8'h25; #1;
    chk("rm.gnt", 8'(bus.gnt), 8'h1);
    tick(); bus.req = 2'b00; #1;
    tick(); #1;
    chk("rm.shift1", 8'(sr_shift_en), 8'h1);
    tick(); #1;
    chk("rm.shift2", 8'(sr_shift_en), 8'h1);
    rst = 1'b1; bus.req = 2'b11;
    tick(); #1; chk_zero("rm.rst0");
    tick(); #1; chk_zero("rm.rst1");
    tick(); rst = 1'b0; #1;
    chk("rm.gnt_after", 8'(bus.gnt), 8'h1);
    chk("rm.nodone", 8'(bus.done), 8'h0);
    tick(); bus.req = 2'b00; #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
